// File: rtl/fib_sync_pkg.sv
// Shared definitions for the sync-protocol Fibonacci responder.
// Holds the FSM state encodings and the default data/counter widths
// so the top, its step sub-module and any bench agree on them.
package fib_sync_pkg;

   // Default data width of in0/out0 and default iteration counter width
   localparam int FIB_N_DEFAULT  = 16;
   localparam int FIB_CW_DEFAULT = 16;

   // Responder FSM states
   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_RUN  = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

endpackage

// File: rtl/fib_step.sv
// One step of the Fibonacci recurrence with overflow tracking.
// Ports:
//   a, b       current pair (fib(k), fib(k+1)) modulo 2^N
//   oa, ob     sticky overflow flags belonging to a and b
//   a_next     next a (old b)
//   b_next     next b (a + b modulo 2^N)
//   oa_next    next oa (old ob)
//   ob_next    next ob (set when any earlier term or this sum overflowed)
module fib_step
#(
   parameter int N = 16
)
(
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   input  logic         oa,
   input  logic         ob,
   output logic [N-1:0] a_next,
   output logic [N-1:0] b_next,
   output logic         oa_next,
   output logic         ob_next
);

   logic [N:0] sum;

   // The extra top bit of the sum is the carry out of the N-bit add;
   // once either term has overflowed every later term has too, so the
   // flag is carried forward along the recurrence.
   always_comb begin
      sum     = {1'b0, a} + {1'b0, b};
      a_next  = b;
      b_next  = sum[N-1:0];
      oa_next = ob;
      ob_next = oa | ob | sum[N];
   end

endmodule

// File: rtl/fib_sync_resp.sv
// Responder end of the sync valid/ready stream: accepts an argument n
// and returns fib(n) modulo 2^N plus an overflow flag.
// Ports:
//   clk        rising-edge clock
//   reset      synchronous active-high reset
//   in_valid   in0 is valid this cycle
//   in_ready   block accepts in0 this cycle
//   in0        argument n, signed two's complement (n<0 treated as 0)
//   out_valid  out0/out1 hold a result
//   out_ready  consumer takes the result this cycle
//   out0       fib(n) mod 2^N
//   out1       overflow: the true fib(n) >= 2^N
module fib_sync_resp
   import fib_sync_pkg::*;
#(
   parameter int N  = FIB_N_DEFAULT,
   parameter int CW = FIB_CW_DEFAULT
)
(
   input  logic         clk,
   input  logic         reset,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [N-1:0] in0,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [N-1:0] out0,
   output logic         out1
);

   logic [1:0]    state;
   logic [N-1:0]  a;
   logic [N-1:0]  b;
   logic          oa;
   logic          ob;
   logic [CW-1:0] cnt;

   logic [N-1:0]  a_next;
   logic [N-1:0]  b_next;
   logic          oa_next;
   logic          ob_next;
   logic          in_fire;

   fib_step #(.N(N)) u_step (
      .a       (a),
      .b       (b),
      .oa      (oa),
      .ob      (ob),
      .a_next  (a_next),
      .b_next  (b_next),
      .oa_next (oa_next),
      .ob_next (ob_next)
   );

   // Ready in IDLE, or in DONE when the current result is leaving on
   // this same edge; the combinational out_ready path gives back-to-back
   // turnaround without an idle bubble.
   always_comb begin
      in_ready  = (state == ST_IDLE) || ((state == ST_DONE) && out_ready);
      in_fire   = in_valid && in_ready;
      out_valid = (state == ST_DONE);
      out0      = out_valid ? a : '0;
      out1      = out_valid & oa;
   end

   // An accepted argument always reloads the recurrence and starts RUN,
   // whether it arrived from IDLE or alongside a DONE hand-off. Negative
   // arguments load a zero iteration count so the result stays fib(0).
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= ST_IDLE;
         a     <= '0;
         b     <= '0;
         oa    <= 1'b0;
         ob    <= 1'b0;
         cnt   <= '0;
      end else if (in_fire) begin
         state <= ST_RUN;
         a     <= '0;
         b     <= N'(1);
         oa    <= 1'b0;
         ob    <= 1'b0;
         cnt   <= in0[N-1] ? '0 : CW'(in0);
      end else begin
         case (state)
            ST_RUN: begin
               if (cnt == '0) begin
                  state <= ST_DONE;
               end else begin
                  a   <= a_next;
                  b   <= b_next;
                  oa  <= oa_next;
                  ob  <= ob_next;
                  cnt <= cnt - CW'(1);
               end
            end
            ST_DONE: begin
               if (out_ready) begin
                  state <= ST_IDLE;
               end
            end
            ST_IDLE: begin
               state <= ST_IDLE;
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_fib_sync_resp.sv
// Self-checking bench for fib_sync_resp: directed scenarios plus random
// arguments, all compared against a wide-integer Fibonacci reference.
module tb_fib_sync_resp;

   localparam int N  = 16;
   localparam int CW = 16;

   logic         clk;
   logic         reset;
   logic         in_valid;
   logic         in_ready;
   logic [N-1:0] in0;
   logic         out_valid;
   logic         out_ready;
   logic [N-1:0] out0;
   logic         out1;

   int errors;
   int checks;

   fib_sync_resp #(.N(N), .CW(CW)) dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in0       (in0),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out0      (out0),
      .out1      (out1)
   );

   // Free-running clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Advance one rising edge and settle 1 time unit past it
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Count one comparison and report it when it does not hold
   task automatic checkOutput(input string tag, input logic [63:0] observed,
                              input logic [63:0] expected);
      checks++;
      if (observed !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0d expected %0d", tag, observed, expected);
      end
   endtask

   // True Fibonacci value in 64 bits (exact for n <= 93); n<0 counts as 0
   function automatic longint unsigned fibRef(input int n);
      longint unsigned x, y, t;
      x = 0;
      y = 1;
      for (int k = 0; k < n; k++) begin
         t = x + y;
         x = y;
         y = t;
      end
      return x;
   endfunction

   // Wait for out_valid, bounded; returns edges taken
   task automatic waitResult(output int edges);
      edges = 0;
      while (!out_valid && edges < 200) begin
         step();
         edges++;
      end
   endtask

   // Present one argument from IDLE, check latency, result, back-pressure
   // hold for bp cycles, then the hand-off back to IDLE
   task automatic applyStimulus(input int n, input int bp);
      longint unsigned ref_val;
      int edges;
      int lat;
      ref_val = fibRef(n);
      lat     = (n < 0 ? 0 : n) + 1;
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in0       = N'(n);
      checkOutput("idle_ready", 64'(in_ready), 64'd1);
      step();
      in_valid = 1'b0;
      in0      = N'($urandom);
      waitResult(edges);
      checkOutput($sformatf("latency n=%0d", n), 64'(edges), 64'(lat));
      checkOutput($sformatf("out0 n=%0d", n), 64'(out0), 64'(ref_val[N-1:0]));
      checkOutput($sformatf("out1 n=%0d", n), 64'(out1),
                  64'(ref_val >= 64'(1 << N)));
      for (int i = 0; i < bp; i++) begin
         in_valid = 1'($urandom);
         step();
         checkOutput("hold_valid", 64'(out_valid), 64'd1);
         checkOutput("hold_out0", 64'(out0), 64'(ref_val[N-1:0]));
         checkOutput("hold_ready", 64'(in_ready), 64'd0);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      #1;
      checkOutput("turn_ready", 64'(in_ready), 64'd1);
      step();
      out_ready = 1'b0;
      checkOutput("post_valid", 64'(out_valid), 64'd0);
      checkOutput("post_ready", 64'(in_ready), 64'd1);
   endtask

   initial begin
      int n;
      int edges;
      longint unsigned ref_val;
      errors    = 0;
      checks    = 0;
      reset     = 1'b1;
      in_valid  = 1'b0;
      in0       = '0;
      out_ready = 1'b0;
      step();
      step();
      reset = 1'b0;
      step();
      checkOutput("rst_valid", 64'(out_valid), 64'd0);
      checkOutput("rst_ready", 64'(in_ready), 64'd1);
      checkOutput("rst_out0", 64'(out0), 64'd0);
      checkOutput("rst_out1", 64'(out1), 64'd0);

      // Directed arguments including negative input and overflow edge
      applyStimulus(10, 0);
      applyStimulus(0, 0);
      applyStimulus(-5, 0);
      applyStimulus(24, 0);
      applyStimulus(25, 0);
      applyStimulus(7, 20);

      // Back-to-back: 3 accepted, then 4 taken on the same edge as result 2
      in_valid  = 1'b1;
      in0       = N'(3);
      out_ready = 1'b1;
      step();
      in0 = N'(4);
      waitResult(edges);
      checkOutput("b2b_lat1", 64'(edges), 64'd4);
      checkOutput("b2b_out0_1", 64'(out0), 64'd2);
      checkOutput("b2b_ready", 64'(in_ready), 64'd1);
      step();
      in_valid = 1'b0;
      checkOutput("b2b_run", 64'(out_valid), 64'd0);
      waitResult(edges);
      checkOutput("b2b_lat2", 64'(edges), 64'd5);
      checkOutput("b2b_out0_2", 64'(out0), 64'd3);
      step();
      out_ready = 1'b0;
      checkOutput("b2b_idle", 64'(in_ready), 64'd1);

      // Reset mid-computation
      in_valid = 1'b1;
      in0      = N'(20);
      step();
      in_valid = 1'b0;
      for (int i = 0; i < 5; i++) step();
      reset = 1'b1;
      step();
      reset = 1'b0;
      checkOutput("mid_rst_valid", 64'(out_valid), 64'd0);
      checkOutput("mid_rst_out0", 64'(out0), 64'd0);
      checkOutput("mid_rst_ready", 64'(in_ready), 64'd1);
      for (int i = 0; i < 25; i++) begin
         step();
         checkOutput("mid_rst_stay", 64'(out_valid), 64'd0);
      end
      applyStimulus(6, 0);

      // Randomized arguments within the exact range of the reference
      for (int i = 0; i < 15; i++) begin
         n = int'($urandom_range(95, 0)) - 5;
         applyStimulus(n, int'($urandom_range(3, 0)));
      end

      // Late check that a known large argument still overflows correctly
      ref_val = fibRef(40);
      in_valid  = 1'b1;
      in0       = N'(40);
      step();
      in_valid = 1'b0;
      waitResult(edges);
      checkOutput("n40_out0", 64'(out0), 64'(ref_val[N-1:0]));
      checkOutput("n40_out1", 64'(out1), 64'd1);
      out_ready = 1'b1;
      step();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
